// File: rtl/uart_recv_hs.sv
// High-speed 8N1 UART receiver: 3-flop synchronizer, start-edge detect, mid-bit sampling, stop-bit check.
// Optional UART_RECV_HS_MAJORITY_EN: 2-of-3 vote around the bit centre, decisions one clock later.
module uart_recv_hs #(
   parameter int BPS_CNT = 25,
   parameter int CNT_W   = 5
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic [7:0] uart_data,
   output logic       uart_done,
   output logic       frame_err,
   output logic       rx_busy
);
   // state | meaning
   // IDLE  | waiting for a falling edge, counters held at 0
   // START | rx_cnt 0, confirm start bit low at the decision point
   // DATA  | rx_cnt 1..8, shift data bits in LSB first
   // STOP  | rx_cnt 9, check stop bit, strobe done or frame_err
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);
`ifdef UART_RECV_HS_MAJORITY_EN
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(BPS_CNT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(BPS_CNT / 2 + 1);
`else
   localparam logic [CNT_W-1:0] CNT_DEC = CNT_MID;
`endif

   state_t           state, state_nxt;
   logic             rxd_d0, rxd_d1, rxd_d2;
   logic             fall;
   logic [CNT_W-1:0] clk_cnt;
   logic [3:0]       rx_cnt;
   logic [7:0]       shift_reg;
   logic             rx_bit;
   logic             sample_pt;
   logic             load_bit;
   logic             done_nxt;
   logic             err_nxt;

   assign fall      = rxd_d2 & ~rxd_d1;
   assign sample_pt = (clk_cnt == CNT_DEC);
   assign rx_busy   = (state != IDLE);

`ifdef UART_RECV_HS_MAJORITY_EN
   logic samp_a, samp_b;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (clk_cnt == CNT_PRE) samp_a <= rxd_d2;
         if (clk_cnt == CNT_MID) samp_b <= rxd_d2;
      end
   end

   // third sample is the live one at the decision point
   assign rx_bit = (samp_a & samp_b) | (samp_a & rxd_d2) | (samp_b & rxd_d2);
`else
   assign rx_bit = rxd_d2;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rxd_d0 <= 1'b1;
         rxd_d1 <= 1'b1;
         rxd_d2 <= 1'b1;
      end else begin
         rxd_d0 <= uart_rxd;
         rxd_d1 <= rxd_d0;
         rxd_d2 <= rxd_d1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= IDLE;
         clk_cnt <= '0;
         rx_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            clk_cnt <= '0;
            rx_cnt  <= '0;
         end else if (clk_cnt == CNT_MAX) begin
            clk_cnt <= '0;
            rx_cnt  <= rx_cnt + 4'd1;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load_bit  = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE:  if (fall) state_nxt = START;
         START: if (sample_pt) state_nxt = rx_bit ? IDLE : DATA;
         DATA: begin
            if (sample_pt) begin
               load_bit = 1'b1;
               if (rx_cnt == 4'd8) state_nxt = STOP;
            end
         end
         STOP: begin
            // leaving at the stop-bit centre lets a back-to-back start edge be caught
            if (sample_pt) begin
               state_nxt = IDLE;
               done_nxt  = rx_bit;
               err_nxt   = ~rx_bit;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_reg <= '0;
         uart_data <= '0;
         uart_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (load_bit) shift_reg <= {rx_bit, shift_reg[7:1]};
         if (done_nxt) uart_data <= shift_reg;
         uart_done <= done_nxt;
         frame_err <= err_nxt;
      end
   end

endmodule
